// File: rtl/cookie_sprite_gen_pkg.sv
// Shared types and constants for the cookie sprite pixel source.
package cookie_sprite_gen_pkg;

    localparam int SPRITE_SIZE = 16;

    typedef logic [5:0] rgb_t;

    localparam rgb_t COOKIE = 6'b10_01_00;
    localparam rgb_t CHIP   = 6'b01_00_00;
    localparam rgb_t BG     = 6'b00_00_01;
    localparam rgb_t BLACK  = 6'b00_00_00;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_UPD_X,
        ST_UPD_Y
    } state_t;

    typedef struct packed {
        logic [9:0] pos;
        logic       dir;
    } axis_t;

    // One bounce step along an axis; 11-bit math so pos+step can never wrap.
    function automatic axis_t bounce(axis_t cur, logic [10:0] limit, logic [10:0] step);
        axis_t       nxt;
        logic [10:0] wide;
        wide = {1'b0, cur.pos};
        nxt  = cur;
        if (!cur.dir) begin
            if (wide + step > limit) begin
                nxt.pos = 10'(limit);
                nxt.dir = 1'b1;
            end else begin
                nxt.pos = 10'(wide + step);
            end
        end else if (wide < step) begin
            nxt.pos = '0;
            nxt.dir = 1'b0;
        end else begin
            nxt.pos = 10'(wide - step);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/cookie_sprite_gen_if.sv
// Timing-generator side of the sprite source: raw counters/sync in, colour out.
interface cookie_sprite_gen_if;
    logic       enable;
    logic [9:0] x;
    logic [9:0] y;
    logic       vs;
    logic [1:0] red_pixel;
    logic [1:0] green_pixel;
    logic [1:0] blue_pixel;

    modport master (
        output enable, x, y, vs,
        input  red_pixel, green_pixel, blue_pixel
    );

    modport slave (
        input  enable, x, y, vs,
        output red_pixel, green_pixel, blue_pixel
    );
endinterface

// File: rtl/cookie_sprite_gen_rom.sv
// 16x16 cookie bitmap: body is the disc with the chips carved out, chip marks the chips.
module cookie_sprite_rom (
    input  logic [3:0]  row,
    output logic [15:0] body,
    output logic [15:0] chip
);
    always_comb begin
        body = '0;
        chip = '0;
        case (row)
            4'd0:  body = 16'h03C0;
            4'd1:  body = 16'h0FF0;
            4'd2:  body = 16'h1FF8;
            4'd3:  body = 16'h3FFC;
            4'd4:  begin body = 16'h7F9E; chip = 16'h0060; end
            4'd5:  begin body = 16'h7F9E; chip = 16'h0060; end
            4'd6:  body = 16'hFFFF;
            4'd7:  begin body = 16'hF3FF; chip = 16'h0C00; end
            4'd8:  begin body = 16'hF3FF; chip = 16'h0C00; end
            4'd9:  body = 16'hFFFF;
            4'd10: begin body = 16'h7FCE; chip = 16'h0030; end
            4'd11: begin body = 16'h79CE; chip = 16'h0630; end
            4'd12: begin body = 16'h39FC; chip = 16'h0600; end
            4'd13: body = 16'h1FF8;
            4'd14: body = 16'h0FF0;
            4'd15: body = 16'h03C0;
            default: begin body = '0; chip = '0; end
        endcase
    end
endmodule

// File: rtl/cookie_sprite_gen.sv
// Bouncing 16x16 cookie over a flat background, 2-clock pixel pipeline.
// state    | meaning
// ST_WAIT  | idle, watching for vs falling edge
// ST_UPD_X | step px/dx one bounce
// ST_UPD_Y | step py/dy one bounce
module cookie_sprite_gen
    import cookie_sprite_gen_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int SPEED    = 2,
    parameter int X0       = 100,
    parameter int Y0       = 80
) (
    input logic                clk,
    input logic                rst_n,
    cookie_sprite_gen_if.slave vga
);
    localparam logic [10:0] X_LIMIT = 11'(H_ACTIVE - SPRITE_SIZE);
    localparam logic [10:0] Y_LIMIT = 11'(V_ACTIVE - SPRITE_SIZE);
    localparam logic [10:0] STEP    = 11'(SPEED);
    localparam logic [10:0] H_END   = 11'(H_ACTIVE);
    localparam logic [10:0] V_END   = 11'(V_ACTIVE);

    state_t     state;
    logic [9:0] px, py;
    logic       dx, dy;
    logic       vs_d;
    logic       frame_evt;
    axis_t      nxt_x, nxt_y;

    assign frame_evt = vs_d && !vga.vs && vga.enable;
    assign nxt_x     = bounce('{pos: px, dir: dx}, X_LIMIT, STEP);
    assign nxt_y     = bounce('{pos: py, dir: dy}, Y_LIMIT, STEP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_WAIT;
            px    <= 10'(X0);
            py    <= 10'(Y0);
            dx    <= 1'b0;
            dy    <= 1'b0;
            vs_d  <= 1'b1;
        end else begin
            vs_d <= vga.vs;
            if (!vga.enable) begin
                state <= ST_WAIT;
            end else begin
                case (state)
                    ST_WAIT: if (frame_evt) state <= ST_UPD_X;
                    ST_UPD_X: begin
                        px    <= nxt_x.pos;
                        dx    <= nxt_x.dir;
                        state <= ST_UPD_Y;
                    end
                    ST_UPD_Y: begin
                        py    <= nxt_y.pos;
                        dy    <= nxt_y.dir;
                        state <= ST_WAIT;
                    end
                    default: state <= ST_WAIT;
                endcase
            end
        end
    end

    // Stage 1: sprite-relative coordinates; 10-bit wrap makes left/above misses large.
    logic [9:0]  rel_x, rel_y;
    logic        hit_c, act_c;
    logic        s1_hit, s1_act;
    logic [3:0]  s1_row, s1_col;
    logic [15:0] rom_body, rom_chip;
    rgb_t        colour, rgb_q;

    assign rel_x = vga.x - px;
    assign rel_y = vga.y - py;
    assign hit_c = (rel_x[9:4] == 6'd0) && (rel_y[9:4] == 6'd0);
    assign act_c = ({1'b0, vga.x} < H_END) && ({1'b0, vga.y} < V_END);

    cookie_sprite_rom u_rom (
        .row  (s1_row),
        .body (rom_body),
        .chip (rom_chip)
    );

    always_comb begin
        colour = BLACK;
        if (s1_act) begin
            if (s1_hit && rom_body[s1_col])      colour = COOKIE;
            else if (s1_hit && rom_chip[s1_col]) colour = CHIP;
            else                                 colour = BG;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !vga.enable) begin
            s1_hit <= 1'b0;
            s1_act <= 1'b0;
            s1_row <= '0;
            s1_col <= '0;
            rgb_q  <= BLACK;
        end else begin
            s1_hit <= hit_c;
            s1_act <= act_c;
            s1_row <= rel_y[3:0];
            s1_col <= rel_x[3:0];
            rgb_q  <= colour;
        end
    end

    assign vga.red_pixel   = rgb_q[5:4];
    assign vga.green_pixel = rgb_q[3:2];
    assign vga.blue_pixel  = rgb_q[1:0];

endmodule
